// File: rtl/conv_layer_window_mac_pkg.sv
// Shared conv-layer definitions: data format, row and kernel geometry, MAC
// state encodings and the input-buffer handshake constants.
// No ports (package).
// Optional build macro used by importers: CONV_LAYER_MAC_RELU_EN.
package conv_layer_window_mac_pkg;

  localparam int DATA_WIDTH  = 32;  // Q16.16 signed pixels, weights, results
  localparam int INPUT_SIZE  = 8;   // pixels per buffer row
  localparam int KERNEL_SIZE = 3;   // only 3 is supported
  localparam int FRAC_BITS   = 16;
  localparam int OUT_SIZE    = INPUT_SIZE - KERNEL_SIZE + 1;
  localparam int NUM_TAPS    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PROD_W      = 2 * DATA_WIDTH;
  localparam int SUM_W       = PROD_W + 4;  // headroom for nine products

  // MAC controller states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Input-buffer command / acknowledge encodings
  localparam logic [1:0] BUF_CMD_IDLE      = 2'd0;
  localparam logic [1:0] BUF_CMD_LOAD      = 2'd1;
  localparam logic [1:0] BUF_CMD_READ      = 2'd2;
  localparam logic       BUF_ACK_LOAD_DONE = 1'b1;

  typedef logic signed [DATA_WIDTH-1:0] pixel_t;
  typedef logic signed [PROD_W-1:0]     prod_t;

endpackage

// File: rtl/conv_layer_sum9_sat.sv
// Combinational reduction of one 3x3 window: sums the nine signed products,
// rescales from Q32.32 to Q16.16 with a flooring arithmetic shift and
// saturates to the signed DATA_WIDTH range.
// Build macro: CONV_LAYER_MAC_RELU_EN clamps negative results to zero.
// Ports:
//   i_prod   - nine signed full-width products of the window
//   o_result - saturated (optionally rectified) Q16.16 result
module conv_layer_sum9_sat
  import conv_layer_window_mac_pkg::*;
(
  input  prod_t  i_prod [NUM_TAPS],
  output pixel_t o_result
);

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  function automatic pixel_t sat_dw(input logic signed [SUM_W-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (x < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return x[DATA_WIDTH-1:0];
  endfunction

  function automatic pixel_t relu(input pixel_t x);
    return x[DATA_WIDTH-1] ? '0 : x;
  endfunction

  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_shifted;
  pixel_t                  w_sat;

  always_comb begin
    w_sum = '0;
    // Products are sign-extended so the wide sum cannot wrap.
    for (int i = 0; i < NUM_TAPS; i++)
      w_sum = w_sum + {{(SUM_W-PROD_W){i_prod[i][PROD_W-1]}}, i_prod[i]};
    w_shifted = w_sum >>> FRAC_BITS;
    w_sat     = sat_dw(w_shifted);
`ifdef CONV_LAYER_MAC_RELU_EN
    o_result  = relu(w_sat);
`else
    o_result  = w_sat;
`endif
  end

endmodule

// File: rtl/conv_layer_window_mac.sv
// 3x3 window MAC behind the conv-layer input buffer. On start it latches the
// kernel, fetches the three buffer rows through array_idx, then issues one
// window column per cycle into a two-stage multiply / reduce pipeline and
// streams OUT_SIZE results with their column index.
// Build macro: CONV_LAYER_MAC_RELU_EN (rectified output, see sub-module).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - begin one output row (honoured in IDLE only)
//   weight_bus  - kernel taps, tap 0 in the MSBs
//   row_bus     - buffer row selected by array_idx, pixel 0 in the MSBs
//   array_idx   - row select to the buffer, 3 when not fetching
//   busy        - operation in progress (FETCH through DONE)
//   out_valid, out_col, out_data - result strobe, column and value
//   done        - one-cycle pulse after the last result
module conv_layer_window_mac
  import conv_layer_window_mac_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [NUM_TAPS*DATA_WIDTH-1:0]   weight_bus,
  input  logic [INPUT_SIZE*DATA_WIDTH-1:0] row_bus,
  output logic [1:0]                       array_idx,
  output logic                             busy,
  output logic                             out_valid,
  output logic [2:0]                       out_col,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             done
);

  logic [2:0] r_state;
  logic [2:0] r_cnt;
  pixel_t     r_w   [NUM_TAPS];
  pixel_t     r_row [KERNEL_SIZE][INPUT_SIZE];
  prod_t      r_prod_p1 [NUM_TAPS];
  logic       r_vld_p1;
  logic [2:0] r_col_p1;
  pixel_t     w_result;

  // r_cnt walks rows in FETCH, columns in COMPUTE and drain cycles in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_state <= ST_FETCH;
          r_cnt   <= '0;
        end
        ST_FETCH: if (r_cnt == 3'(KERNEL_SIZE-1)) begin
          r_state <= ST_COMPUTE;
          r_cnt   <= '0;
        end else r_cnt <= r_cnt + 3'd1;
        ST_COMPUTE: if (r_cnt == 3'(OUT_SIZE-1)) begin
          r_state <= ST_DRAIN;
          r_cnt   <= '0;
        end else r_cnt <= r_cnt + 3'd1;
        ST_DRAIN: if (r_cnt == 3'd1) begin
          r_state <= ST_DONE;
          r_cnt   <= '0;
        end else r_cnt <= r_cnt + 3'd1;
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Kernel and row latches: written only at start / during FETCH so later
  // bus activity cannot disturb an operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) r_w[i] <= '0;
      for (int r = 0; r < KERNEL_SIZE; r++)
        for (int j = 0; j < INPUT_SIZE; j++) r_row[r][j] <= '0;
    end else begin
      if (r_state == ST_IDLE && start)
        for (int i = 0; i < NUM_TAPS; i++)
          r_w[i] <= weight_bus[(NUM_TAPS-i)*DATA_WIDTH-1 -: DATA_WIDTH];
      if (r_state == ST_FETCH)
        for (int j = 0; j < INPUT_SIZE; j++)
          r_row[r_cnt[1:0]][j] <= row_bus[(INPUT_SIZE-j)*DATA_WIDTH-1 -: DATA_WIDTH];
    end
  end

  // ---- stage p1: nine window products for column r_cnt ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) r_prod_p1[i] <= '0;
      r_vld_p1 <= 1'b0;
      r_col_p1 <= '0;
    end else begin
      r_vld_p1 <= (r_state == ST_COMPUTE);
      if (r_state == ST_COMPUTE) begin
        r_col_p1 <= r_cnt;
        for (int r = 0; r < KERNEL_SIZE; r++)
          for (int k = 0; k < KERNEL_SIZE; k++)
            r_prod_p1[r*KERNEL_SIZE+k] <= prod_t'(r_row[r][r_cnt + 3'(k)])
                                        * prod_t'(r_w[r*KERNEL_SIZE+k]);
      end
    end
  end

  conv_layer_sum9_sat u_sum9_sat (
    .i_prod   (r_prod_p1),
    .o_result (w_result)
  );

  // ---- stage p2: reduced result onto the output port ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_col   <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= r_vld_p1;
      if (r_vld_p1) begin
        out_col  <= r_col_p1;
        out_data <= w_result;
      end
    end
  end

  assign array_idx = (r_state == ST_FETCH) ? r_cnt[1:0] : 2'd3;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_conv_layer_window_mac.sv
module tb_conv_layer_window_mac;
  import conv_layer_window_mac_pkg::*;

  logic                             clk = 1'b0;
  logic                             rst_n;
  logic                             start;
  logic [NUM_TAPS*DATA_WIDTH-1:0]   weight_bus;
  logic [INPUT_SIZE*DATA_WIDTH-1:0] row_bus;
  logic [1:0]                       array_idx;
  logic                             busy, out_valid, done;
  logic [2:0]                       out_col;
  logic [DATA_WIDTH-1:0]            out_data;

  typedef struct packed {
    logic [2:0]  col;
    logic [31:0] data;
  } exp_t;

  exp_t              exp_q[$];
  logic signed [31:0] tb_rows [3][8];
  logic signed [31:0] tb_w [9];
  int checks = 0;
  int errors = 0;

  conv_layer_window_mac dut (
    .clk(clk), .rst_n(rst_n), .start(start), .weight_bus(weight_bus),
    .row_bus(row_bus), .array_idx(array_idx), .busy(busy),
    .out_valid(out_valid), .out_col(out_col), .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;

  // Buffer model: selected row presented combinationally.
  always_comb begin
    row_bus = '0;
    if (array_idx < 2'd3)
      for (int j = 0; j < 8; j++)
        row_bus[(8-j)*32-1 -: 32] = tb_rows[array_idx][j];
  end

  task automatic drive_weights();
    for (int i = 0; i < 9; i++) weight_bus[(9-i)*32-1 -: 32] = tb_w[i];
  endtask

  task automatic fill(input logic [31:0] pix, input logic [31:0] wt);
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 8; j++) tb_rows[r][j] = pix;
    for (int i = 0; i < 9; i++) tb_w[i] = wt;
    drive_weights();
  endtask

  function automatic logic [31:0] rnd_fx();
    return 32'($urandom_range(32'h0008_0000, 0)) - 32'h0004_0000;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 8; j++) tb_rows[r][j] = rnd_fx();
    for (int i = 0; i < 9; i++) tb_w[i] = rnd_fx();
    drive_weights();
  endtask

  // Reference: exact wide sum, floor shift, saturate, optional ReLU.
  function automatic logic [31:0] model(input int c);
    logic signed [67:0] acc;
    logic signed [63:0] p;
    logic signed [67:0] sh;
    logic [31:0]        res;
    acc = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) begin
        p = $signed({{32{tb_rows[r][c+k][31]}}, tb_rows[r][c+k]})
          * $signed({{32{tb_w[r*3+k][31]}}, tb_w[r*3+k]});
        acc = acc + $signed({{4{p[63]}}, p});
      end
    sh = acc >>> 16;
    if (sh > 68'sh7FFFFFFF)          res = 32'h7FFFFFFF;
    else if (sh < -(68'sh80000000))  res = 32'h80000000;
    else                             res = sh[31:0];
`ifdef CONV_LAYER_MAC_RELU_EN
    if (res[31]) res = 32'h0;
`endif
    return res;
  endfunction

  task automatic push_model();
    for (int c = 0; c < 6; c++) exp_q.push_back('{col: 3'(c), data: model(c)});
  endtask

  task automatic push_const(input logic [31:0] v);
    for (int c = 0; c < 6; c++) exp_q.push_back('{col: 3'(c), data: v});
  endtask

  // Leaves time at posedge+1 of cycle 1.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; weight_bus = '0;
    fill(32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (array_idx !== 2'd3) begin errors++; $display("FAIL reset_idx got %0d want 3", array_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_col !== 3'd0) begin errors++; $display("FAIL reset_col got %0d want 0", out_col); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    exp_t e;
    fill(32'h0001_0000, 32'h0001_0000);
    exp_q.delete();
    push_const(32'h0009_0000);
    pulse_start();
    for (int k = 1; k <= 14; k++) begin
      int exp_idx;
      exp_idx = (k <= 3) ? k - 1 : 3;
      checks++; if (array_idx !== 2'(exp_idx)) begin errors++; $display("FAIL basic_idx cyc %0d got %0d want %0d", k, array_idx, exp_idx); end
      checks++; if (busy !== (k <= 12)) begin errors++; $display("FAIL basic_busy cyc %0d got %b want %b", k, busy, (k <= 12)); end
      checks++; if (done !== (k == 12)) begin errors++; $display("FAIL basic_done cyc %0d got %b want %b", k, done, (k == 12)); end
      checks++; if (out_valid !== (k >= 6 && k <= 11)) begin errors++; $display("FAIL basic_valid cyc %0d got %b", k, out_valid); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (out_col !== e.col || out_data !== e.data) begin errors++; $display("FAIL basic_out cyc %0d got col %0d data %h want col %0d data %h", k, out_col, out_data, e.col, e.data); end
      end
      if (k == 13) begin
        checks++; if (out_data !== 32'h0009_0000) begin errors++; $display("FAIL basic_hold got %h want 00090000", out_data); end
      end
      @(posedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_missing got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_shift();
    exp_t e;
    fill(32'h0, 32'h0);
    for (int j = 0; j < 8; j++) tb_rows[1][j] = 32'(j) << 16;
    tb_w[4] = 32'h0001_0000;
    drive_weights();
    exp_q.delete();
    for (int c = 0; c < 6; c++) exp_q.push_back('{col: 3'(c), data: 32'(c + 1) << 16});
    pulse_start();
    for (int k = 1; k <= 13; k++) begin
      checks++; if (out_valid !== (k >= 6 && k <= 11)) begin errors++; $display("FAIL shift_valid cyc %0d got %b", k, out_valid); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (out_col !== e.col || out_data !== e.data) begin errors++; $display("FAIL shift_out cyc %0d got col %0d data %h want col %0d data %h", k, out_col, out_data, e.col, e.data); end
      end
      @(posedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL shift_missing got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_saturate();
    exp_t e;
    for (int v = 0; v < 2; v++) begin
      fill(32'h7FFF_0000, (v == 0) ? 32'h7FFF_0000 : 32'h8001_0000);
      exp_q.delete();
      if (v == 0) push_const(32'h7FFF_FFFF);
`ifdef CONV_LAYER_MAC_RELU_EN
      else push_const(32'h0000_0000);
`else
      else push_const(32'h8000_0000);
`endif
      pulse_start();
      for (int k = 1; k <= 13; k++) begin
        checks++; if (out_valid !== (k >= 6 && k <= 11)) begin errors++; $display("FAIL sat%0d_valid cyc %0d got %b", v, k, out_valid); end
        if (out_valid === 1'b1 && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++; if (out_col !== e.col || out_data !== e.data) begin errors++; $display("FAIL sat%0d_out cyc %0d got col %0d data %h want col %0d data %h", v, k, out_col, out_data, e.col, e.data); end
        end
        @(posedge clk); #1;
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sat%0d_missing got %0d pending want 0", v, exp_q.size()); end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    fill(32'h0001_0000, 32'h0001_0000);
    exp_q.delete();
    push_const(32'h0009_0000);
    pulse_start();
    for (int k = 1; k <= 7; k++) begin
      checks++; if (out_valid !== (k == 6 || k == 7)) begin errors++; $display("FAIL abort_valid cyc %0d got %b", k, out_valid); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (out_col !== e.col || out_data !== e.data) begin errors++; $display("FAIL abort_out cyc %0d got col %0d data %h want col %0d data %h", k, out_col, out_data, e.col, e.data); end
      end
      if (k < 7) begin @(posedge clk); #1; end
    end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_col !== 3'd0) begin errors++; $display("FAIL abort_out_reset got v %b col %0d data %h want 0 0 0", out_valid, out_col, out_data); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || array_idx !== 2'd3) begin errors++; $display("FAIL abort_ctl_reset got busy %b done %b idx %0d want 0 0 3", busy, done, array_idx); end
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_quiet cyc %0d got %b want 0", k, out_valid); end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle cyc %0d got v %b busy %b want 0 0", k, out_valid, busy); end
    end
    test_basic();
  endtask

  task automatic test_ignore();
    exp_t e;
    fill_random();
    exp_q.delete();
    push_model();
    pulse_start();
    for (int k = 1; k <= 14; k++) begin
      checks++; if (out_valid !== (k >= 6 && k <= 11)) begin errors++; $display("FAIL ign_valid cyc %0d got %b", k, out_valid); end
      checks++; if (busy !== (k <= 12)) begin errors++; $display("FAIL ign_busy cyc %0d got %b want %b", k, busy, (k <= 12)); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (out_col !== e.col || out_data !== e.data) begin errors++; $display("FAIL ign_out cyc %0d got col %0d data %h want col %0d data %h", k, out_col, out_data, e.col, e.data); end
      end
      if (k == 4) fill_random();
      start = (k == 5 || k == 12);
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ign_missing got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    fill_random();
    exp_q.delete();
    push_model();
    pulse_start();
    for (int k = 1; k <= 27; k++) begin
      checks++; if (out_valid !== ((k >= 6 && k <= 11) || (k >= 19 && k <= 24))) begin errors++; $display("FAIL b2b_valid cyc %0d got %b", k, out_valid); end
      checks++; if (busy !== (k <= 12 || (k >= 14 && k <= 25))) begin errors++; $display("FAIL b2b_busy cyc %0d got %b", k, busy); end
      checks++; if (done !== (k == 12 || k == 25)) begin errors++; $display("FAIL b2b_done cyc %0d got %b", k, done); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (out_col !== e.col || out_data !== e.data) begin errors++; $display("FAIL b2b_out cyc %0d got col %0d data %h want col %0d data %h", k, out_col, out_data, e.col, e.data); end
      end
      if (k == 13) begin
        fill_random();
        push_model();
      end
      start = (k == 13);
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shift();
    test_saturate();
    test_abort();
    test_ignore();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
